// File: rtl/arnold_reset_sequencer.sv
// Reset/clock-divider sequencer for the Arnold clock/reset controller.
// Holds the target in reset for a minimum time plus a settle window before release.
module arnold_reset_sequencer #(
  parameter logic [31:0] DEFAULT_CLKDIV = 32'd0,
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned SETTLE_CYCLES  = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [31:0] cmd_data_i,
  input  logic        abort_i,
  output logic [31:0] control_o,
  output logic [31:0] clkdiv_o,
  output logic [1:0]  state_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    StHold   = 2'd0,
    StAssert = 2'd1,
    StSettle = 2'd2,
    StRun    = 2'd3
  } state_e;

  localparam logic [1:0] OpNop      = 2'b00;
  localparam logic [1:0] OpSetDiv   = 2'b01;
  localparam logic [1:0] OpResetRun = 2'b10;
  localparam logic [1:0] OpHold     = 2'b11;

  localparam int unsigned     RstEff     = (RST_CYCLES == 0) ? 1 : RST_CYCLES;
  localparam bit              SkipSettle = (SETTLE_CYCLES == 0);
  localparam logic [CNT_W-1:0] RstLast    = CNT_W'(RstEff - 1);
  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax     = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resume_q, resume_d;
  logic [31:0]      clkdiv_q, clkdiv_d;
  logic             release_q, release_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             accept;
  state_e           exit_state;

  assign cmd_ready_o = ready_q & ~abort_i;
  assign accept      = cmd_valid_i & cmd_ready_o;
  assign exit_state  = resume_q ? StRun : StHold;

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    resume_d = resume_q;
    clkdiv_d = clkdiv_q;
    if (abort_i) begin
      state_d  = StHold;
      cnt_d    = '0;
      resume_d = 1'b0;
    end else begin
      unique case (state_q)
        StHold, StRun: begin
          cnt_d = '0;
          if (accept) begin
            case (cmd_op_i)
              OpSetDiv: begin
                clkdiv_d = cmd_data_i;
                resume_d = (state_q == StRun);
                state_d  = StAssert;
              end
              OpResetRun: begin
                resume_d = 1'b1;
                state_d  = StAssert;
              end
              OpHold:  state_d = StHold;
              OpNop:   ;
              default: ;
            endcase
          end
        end
        StAssert: begin
          if (cnt_q == RstLast) begin
            cnt_d   = '0;
            state_d = SkipSettle ? exit_state : StSettle;
          end
        end
        StSettle: begin
          if (cnt_q == SettleLast) begin
            cnt_d   = '0;
            state_d = exit_state;
          end
        end
        default: state_d = StHold;
      endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as state.
    release_d = (state_d == StRun);
    done_d    = (state_d == StRun) && (state_q != StRun);
    busy_d    = (state_d == StAssert) || (state_d == StSettle);
    ready_d   = (state_d == StHold) || (state_d == StRun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StHold;
      cnt_q     <= '0;
      resume_q  <= 1'b0;
      clkdiv_q  <= DEFAULT_CLKDIV;
      release_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      resume_q  <= resume_d;
      clkdiv_q  <= clkdiv_d;
      release_q <= release_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign control_o = {31'b0, release_q};
  assign clkdiv_o  = clkdiv_q;
  assign state_o   = state_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule
